udp_echo_agent: RTL
===================

UDP_ECHO_AGENT -- requirements
Module: udp_echo_agent

Interface
REQ-001 SHALL have parameter RXBUF_AWIDTH, default 6, rx buffer word-address width.
REQ-002 SHALL have parameter TXBUF_AWIDTH, default 6, tx buffer word-address width.
REQ-003 SHALL have parameter BUF_WORDS, default 16, local capture depth in 32-bit words (min 4).
REQ-004 SHALL have parameter ECHO_SRC_PORT, default 16'd1234, source port of echoed datagrams.
REQ-005 SHALL have parameters LED_LO_MAX, default 10, and LED_MID_MAX, default 20, size thresholds in bytes.
REQ-006 clk_int  input  1  clock; all logic on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 rxbuf_addr/rxbuf_ce/rxbuf_we/rxbuf_wdata  input  RXBUF_AWIDTH/1/1/32  rx buffer write port snooped from the ROS2 core.
REQ-009 rxbuf_cpu_grant  input  1  received datagram complete, buffer owned by agent.
REQ-010 rxbuf_cpu_rel  output  1  one-cycle pulse returning rx buffer to core.
REQ-011 txbuf_cpu_grant  input  1  tx buffer owned by agent.
REQ-012 txbuf_addr  input  TXBUF_AWIDTH  core read address; txbuf_rdata  output  32  read data.
REQ-013 txbuf_cpu_rel  output  1  one-cycle pulse: tx message ready for transmission.
REQ-014 led  output  3  {blue, green, red} size indicator of last received datagram.
REQ-015 ovf_cnt  output  8  saturating count of truncated datagrams.

Function
REQ-016 Rx format SHALL be: word0 source IP, word1 {size[31:16], source port[15:0]}, word2.. payload.
REQ-017 Every cycle with rxbuf_ce&rxbuf_we and rxbuf_addr<BUF_WORDS SHALL write rxbuf_wdata into capture RAM at rxbuf_addr; higher addresses SHALL be discarded and set a sticky truncate flag.
REQ-018 FSM states SHALL be IDLE, RX_REL, TX_WAIT, TX_REL.
REQ-019 IDLE: rxbuf_cpu_grant=1 -> RX_REL; capture RAM copied into tx image, last size latched.
REQ-020 RX_REL: rxbuf_cpu_rel=1 for exactly one cycle -> TX_WAIT; truncate flag cleared, ovf_cnt incremented (saturate at 255) if flag was set.
REQ-021 TX_WAIT: txbuf_cpu_grant=1 -> TX_REL; otherwise hold.
REQ-022 TX_REL: txbuf_cpu_rel=1 for exactly one cycle -> IDLE.
REQ-023 While not IDLE, rxbuf_cpu_grant SHALL be ignored and rxbuf_cpu_rel held low (backpressure); new rx writes SHALL NOT alter the tx image.
REQ-024 Tx image SHALL be: word0 = rx word0, word1 = {rx source port, ECHO_SRC_PORT}, word2 = {16'd0, size'}, word3..BUF_WORDS = rx word2..BUF_WORDS-1, beyond = 0.
REQ-025 size' SHALL equal min(size, 4*(BUF_WORDS-2)).
REQ-026 txbuf_rdata SHALL be registered, valid one cycle after txbuf_addr, and remain stable from TX_REL until the next RX_REL.
REQ-027 led SHALL be 3'b001 for size 1..LED_LO_MAX, 3'b010 for LED_LO_MAX+1..LED_MID_MAX, 3'b100 above LED_MID_MAX, 3'b000 for size 0; size compared as unsigned 16-bit.
REQ-028 Simultaneous rxbuf_cpu_grant and txbuf_cpu_grant in IDLE SHALL take the rx path; tx grant is ignored until TX_WAIT.

Reset
REQ-029 rst_n low SHALL force IDLE, rxbuf_cpu_rel=0, txbuf_cpu_rel=0, txbuf_rdata=0, led=0, ovf_cnt=0, truncate flag=0, last size=0 immediately.
REQ-030 Reset mid-transaction SHALL abandon pending echo; capture RAM contents need not be cleared.

Configuration
REQ-031 Macro UDP_ECHO_HEARTBEAT_EN defined: a HB_PERIOD-cycle counter (parameter, default 2^27) SHALL, on expiry in IDLE with no rx grant, load a fixed 5-word heartbeat image (parameter HB_WORDS) and enter TX_WAIT; counter restarts on expiry and is held while not IDLE.
REQ-032 Macro undefined: no counter or heartbeat logic; tx only as echo.

Verification
REQ-033 Rx 7-byte datagram (word0 0x0a01a8c0, word1 0x000704d2, payload "foobar\n") + grant -> one rel pulse, led=001, tx image word1=0x04d204d2, word2=7.
REQ-034 Rx size 15 then 25 -> led 010 then 100; size 0 -> led 000.
REQ-035 Rx 100 bytes, BUF_WORDS=16 -> word2=56, ovf_cnt=1; 256 overflows -> ovf_cnt stays 255.
REQ-036 Second rxbuf_cpu_grant while TX_WAIT -> no rxbuf_cpu_rel until after txbuf_cpu_rel; tx image unchanged.
REQ-037 rst_n low during TX_WAIT -> all outputs 0 same cycle, no txbuf_cpu_rel after release.
REQ-038 With UDP_ECHO_HEARTBEAT_EN, HB_PERIOD=100, grant tied high -> txbuf_cpu_rel every 102 cycles, heartbeat image read back.

Source files
------------

// File: rtl/udp_echo_agent.sv
// rtl/udp_echo_agent.sv - UDP echo agent: snoops rx datagrams, builds echo tx image (optional heartbeat: UDP_ECHO_HEARTBEAT_EN)
module udp_echo_agent #(
    parameter int          RXBUF_AWIDTH  = 6,
    parameter int          TXBUF_AWIDTH  = 6,
    parameter int          BUF_WORDS     = 16,
    parameter logic [15:0] ECHO_SRC_PORT = 16'd1234,
    parameter int          LED_LO_MAX    = 10,
    parameter int          LED_MID_MAX   = 20
`ifdef UDP_ECHO_HEARTBEAT_EN
    ,
    parameter int           HB_PERIOD = 2**27,
    parameter logic [159:0] HB_WORDS  = {32'h0000_0000, 32'h4842_4254, 32'h0000_0004,
                                         32'h04d2_04d2, 32'hffff_ffff}
`endif
) (
    input  logic                    clk_int,
    input  logic                    rst_n,
    input  logic [RXBUF_AWIDTH-1:0] rxbuf_addr,
    input  logic                    rxbuf_ce,
    input  logic                    rxbuf_we,
    input  logic [31:0]             rxbuf_wdata,
    input  logic                    rxbuf_cpu_grant,
    output logic                    rxbuf_cpu_rel,
    input  logic                    txbuf_cpu_grant,
    input  logic [TXBUF_AWIDTH-1:0] txbuf_addr,
    output logic [31:0]             txbuf_rdata,
    output logic                    txbuf_cpu_rel,
    output logic [2:0]              led,
    output logic [7:0]              ovf_cnt
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RX_REL  = 2'd1;
    localparam logic [1:0] TX_WAIT = 2'd2;
    localparam logic [1:0] TX_REL  = 2'd3;

    // The tx image is one word longer than the capture: the inserted size word shifts the payload.
    localparam int          IMG_WORDS = BUF_WORDS + 1;
    localparam logic [15:0] MAX_SIZE  = 16'(4 * (BUF_WORDS - 2));

    logic [1:0]  state;
    logic [31:0] cap_ram  [BUF_WORDS];
    logic [31:0] tx_img   [IMG_WORDS];
    logic [31:0] img_next [IMG_WORDS];
    logic [31:0] rd_next;
    logic [15:0] cap_size;
    logic [15:0] size_clip;
    logic [15:0] last_size;
    logic        trunc_flag;
    logic        wr_req;
    logic        wr_hit;
    logic        wr_drop;
    logic        load_echo;
    logic        load_hb;

    assign wr_req    = rxbuf_ce & rxbuf_we;
    assign wr_drop   = wr_req & ~wr_hit;
    assign load_echo = (state == IDLE) & rxbuf_cpu_grant;
    assign cap_size  = cap_ram[1][31:16];
    assign size_clip = (cap_size > MAX_SIZE) ? MAX_SIZE : cap_size;

    assign rxbuf_cpu_rel = (state == RX_REL);
    assign txbuf_cpu_rel = (state == TX_REL);

`ifdef UDP_ECHO_HEARTBEAT_EN
    localparam int HB_W = (HB_PERIOD > 2) ? $clog2(HB_PERIOD) : 1;

    logic [HB_W-1:0] hb_cnt;
    logic            hb_expire;

    assign hb_expire = (hb_cnt == HB_W'(HB_PERIOD - 1));
    assign load_hb   = (state == IDLE) & ~rxbuf_cpu_grant & hb_expire;

    // Heartbeat timer runs only in IDLE and wraps on every expiry, even if rx wins that cycle.
    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt <= '0;
        end else if (state == IDLE) begin
            hb_cnt <= hb_expire ? '0 : hb_cnt + 1'b1;
        end
    end
`else
    assign load_hb = 1'b0;
`endif

    // Decode whether the snooped write lands inside the capture window.
    always_comb begin
        wr_hit = 1'b0;
        for (int i = 0; i < BUF_WORDS; i++) begin
            if (rxbuf_addr == RXBUF_AWIDTH'(i)) wr_hit = 1'b1;
        end
    end

    // Capture RAM keeps snooping in every state; only the tx image is frozen.
    always_ff @(posedge clk_int) begin
        for (int i = 0; i < BUF_WORDS; i++) begin
            if (wr_req && rxbuf_addr == RXBUF_AWIDTH'(i)) cap_ram[i] <= rxbuf_wdata;
        end
    end

    // Build the next tx image: echo rewrite of the capture, or the fixed heartbeat.
    always_comb begin
        for (int k = 0; k < IMG_WORDS; k++) img_next[k] = '0;
`ifdef UDP_ECHO_HEARTBEAT_EN
        if (load_hb) begin
            for (int k = 0; k < 5; k++) img_next[k] = HB_WORDS[k*32 +: 32];
        end else
`endif
        begin
            img_next[0] = cap_ram[0];
            img_next[1] = {cap_ram[1][15:0], ECHO_SRC_PORT};
            img_next[2] = {16'd0, size_clip};
            for (int k = 3; k < IMG_WORDS; k++) img_next[k] = cap_ram[k-1];
        end
    end

    // Tx image changes only when a new echo or heartbeat is accepted in IDLE.
    always_ff @(posedge clk_int) begin
        if (load_echo || load_hb) begin
            for (int k = 0; k < IMG_WORDS; k++) tx_img[k] <= img_next[k];
        end
    end

    // Read mux; addresses past the image return zero.
    always_comb begin
        rd_next = '0;
        for (int k = 0; k < IMG_WORDS; k++) begin
            if (txbuf_addr == TXBUF_AWIDTH'(k)) rd_next = tx_img[k];
        end
    end

    // Registered tx read port.
    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) txbuf_rdata <= '0;
        else        txbuf_rdata <= rd_next;
    end

    // Handshake FSM; rx grant always wins over heartbeat and tx grant in IDLE.
    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (rxbuf_cpu_grant) state <= RX_REL;
                    else if (load_hb)    state <= TX_WAIT;
                end
                RX_REL:  state <= TX_WAIT;
                TX_WAIT: if (txbuf_cpu_grant) state <= TX_REL;
                TX_REL:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Latch the raw datagram size for the indicator when an echo is accepted.
    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n)         last_size <= '0;
        else if (load_echo) last_size <= cap_size;
    end

    // Truncation is sticky per datagram and folded into the overflow count on rx release.
    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            trunc_flag <= 1'b0;
            ovf_cnt    <= '0;
        end else begin
            if (state == RX_REL) begin
                trunc_flag <= 1'b0;
                if (trunc_flag && ovf_cnt != 8'hff) ovf_cnt <= ovf_cnt + 8'd1;
            end
            if (wr_drop) trunc_flag <= 1'b1;
        end
    end

    // Size indicator: {blue, green, red}.
    always_comb begin
        if (last_size == 16'd0)                    led = 3'b000;
        else if (last_size <= 16'(LED_LO_MAX))     led = 3'b001;
        else if (last_size <= 16'(LED_MID_MAX))    led = 3'b010;
        else                                       led = 3'b100;
    end

endmodule
